fx_to_ft_seq: RTL and testbench

Multi-cycle converter from the accelerator's 24-bit signed fixed-point format (two's complement, 22 fractional bits, range [-2.0, 2.0)) to IEEE-754 single precision. It is the output-side counterpart of the float-to-fixed input stage: the accelerator core produces a fixed-point result and this block packs it into the 32-bit float returned to the Nios II. It uses the Nios II custom-instruction handshake (`clk_en`, `start`, `done`). The conversion is exact: at most 23 significant bits remain below the leading one, so no rounding is required.

---
 rtl/accel_pkg.sv | 27 ++
 rtl/lzc24.sv | 21 ++
 rtl/fx_to_ft_seq.sv | 138 +++++++++++++
 tb/tb_fx_to_ft_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared widths, exponent offset and state encoding for the
// fixed-point to single-precision output stage.
package accel_pkg;

  localparam int FX_W      = 24;
  localparam int FX_FRAC   = 22;
  localparam int FT_W      = 32;
  localparam int FT_BIAS   = 127;
  localparam int FT_MANT_W = 23;
  localparam int FT_EXP_W  = 8;
  localparam int CNT_W     = 5;

  // The normalisation counter ends at the leading-one position p; the
  // biased exponent is p - FX_FRAC + FT_BIAS.
  localparam logic [FT_EXP_W-1:0] FT_EXP_OFS = FT_EXP_W'(FT_BIAS - FX_FRAC);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK
  } fx2ft_state_t;

  function automatic logic [FT_EXP_W-1:0] pack_exp(input logic [CNT_W-1:0] cnt);
    return FT_EXP_W'(cnt) + FT_EXP_OFS;
  endfunction

endpackage

// File: rtl/lzc24.sv
// lzc24: combinational 24-bit leading-zero counter with an all-zero flag.
// An all-zero input reports a count of 24.
module lzc24
  import accel_pkg::*;
(
  input  logic [FX_W-1:0]  i_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    o_cnt = CNT_W'(FX_W);
    for (int i = 0; i < FX_W; i++) begin
      if (i_data[i]) o_cnt = CNT_W'(FX_W - 1 - i);
    end
  end

  assign o_zero = (i_data == '0);

endmodule

// File: rtl/fx_to_ft_seq.sv
// fx_to_ft_seq: multi-cycle converter from 24-bit signed Q2.22 fixed point
// to IEEE-754 single precision behind a Nios II custom-instruction handshake.
// The conversion is exact; no rounding stage exists.
// Build option FX_TO_FT_FAST_NORM_EN: normalise in a single edge using lzc24
// instead of shifting one bit per edge. Results are identical either way.
//
// state | meaning
// IDLE  | waiting for start; holds last result
// NORM  | shifting magnitude until its MSB is set (or zero detected)
// PACK  | assemble the float, pulse done, release busy
module fx_to_ft_seq
  import accel_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            start,
  input  logic [FX_W-1:0] dataa,
  output logic [FT_W-1:0] result,
  output logic            done,
  output logic            busy
);

  fx2ft_state_t r_state, w_state_nxt;

  logic             r_sign,   w_sign_nxt;
  logic [FX_W-1:0]  r_mag,    w_mag_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_zero,   w_zero_nxt;
  logic [FT_W-1:0]  r_result, w_result_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_busy,   w_busy_nxt;

  // -2.0 negates to itself, which is exactly the magnitude wanted.
  logic [FX_W-1:0]  w_abs;
  assign w_abs = dataa[FX_W-1] ? (-dataa) : dataa;

`ifdef FX_TO_FT_FAST_NORM_EN
  logic [CNT_W-1:0] w_lz_cnt;
  logic             w_lz_zero;

  lzc24 u_lzc (
    .i_data (r_mag),
    .o_cnt  (w_lz_cnt),
    .o_zero (w_lz_zero)
  );
`endif

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_mag_nxt    = r_mag;
    w_cnt_nxt    = r_cnt;
    w_zero_nxt   = r_zero;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sign_nxt  = dataa[FX_W-1];
          w_mag_nxt   = w_abs;
          w_cnt_nxt   = CNT_W'(FX_W - 1);
          w_zero_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
`ifdef FX_TO_FT_FAST_NORM_EN
        if (w_lz_zero) begin
          w_zero_nxt = 1'b1;
        end else begin
          w_mag_nxt = r_mag << w_lz_cnt;
          w_cnt_nxt = CNT_W'(FX_W - 1) - w_lz_cnt;
        end
        w_state_nxt = PACK;
`else
        if (r_mag == '0) begin
          w_zero_nxt  = 1'b1;
          w_state_nxt = PACK;
        end else if (r_mag[FX_W-1]) begin
          w_state_nxt = PACK;
        end else begin
          w_mag_nxt = r_mag << 1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
`endif
      end
      PACK: begin
        // The hidden one sits at mag[23]; bits below it are the fraction.
        w_result_nxt = r_zero ? '0 : {r_sign, pack_exp(r_cnt), r_mag[FT_MANT_W-1:0]};
        w_done_nxt   = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; advances only on enabled edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; a disabled edge freezes them, done included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (clk_en) begin
      r_sign   <= w_sign_nxt;
      r_mag    <= w_mag_nxt;
      r_cnt    <= w_cnt_nxt;
      r_zero   <= w_zero_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_fx_to_ft_seq.sv
// Testbench for fx_to_ft_seq: driver issues conversions and queues the
// expected float and completion edge; an independent monitor checks each done.
module tb_fx_to_ft_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [23:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;

  fx_to_ft_seq dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

`ifdef FX_TO_FT_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    int          edge_n;
    logic [23:0] din;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  logic en_last = 1'b0;
  bit   rand_en = 1'b0;
  bit   ign_start = 1'b0;

  // Count enabled edges; latency is measured in these.
  always @(posedge clk) begin
    en_last <= clk_en;
    if (clk_en) en_cnt <= en_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic real fx_real(input logic [23:0] d);
    int sx;
    sx = {{8{d[23]}}, d};
    return real'(sx) / 4194304.0;
  endfunction

  // Repack the exact double value as a single; the value has at most 24
  // significant bits so the top 23 double fraction bits are exact.
  function automatic logic [31:0] ref_float(input logic [23:0] d);
    real         v;
    logic [63:0] b;
    int          e;
    v = fx_real(d);
    if (v == 0.0) return 32'h0;
    b = $realtobits(v);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic int ref_lat(input logic [23:0] d);
    real         v;
    logic [63:0] b;
    int          p;
    v = fx_real(d);
    if (FAST || v == 0.0) return 3;
    b = $realtobits(v);
    p = int'(b[62:52]) - 1023 + 22;
    return (23 - p) + 3;
  endfunction

  function automatic int lat_sel(input int it);
    return FAST ? 3 : it;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    int   last_done;
    logic prev_done;
    last_done = -1;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done && !en_last) chk("done_hold", 32'(done), 32'd1);
      else if (prev_done && en_last) chk("done_pulse", 32'(done), 32'd0);
      if (done && en_cnt != last_done) begin
        last_done = en_cnt;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result 0x%08h, required no completion", result);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("result[%06h]", e.din), result, e.res);
          chk($sformatf("done_edge[%06h]", e.din), 32'(en_cnt), 32'(e.edge_n));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_idle_cycle();
    clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    start  = ign_start ? 1'($urandom_range(0, 1)) : 1'b0;
    dataa  = 24'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 400) begin
      drive_idle_cycle();
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", guard);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [23:0] d, input logic [31:0] er, input int lat);
    exp_t e;
    wait_idle();
    clk_en   = 1'b1;
    start    = 1'b1;
    dataa    = d;
    e.res    = er;
    e.edge_n = en_cnt + lat;
    e.din    = d;
    sb_q.push_back(e);
    @(negedge clk);
    drive_idle_cycle();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached with %0d completions outstanding, required 0", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  logic [23:0] corners [8];
  logic [23:0] d;
  int          g;

  initial begin : main
    corners = '{24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF,
                24'h000000, 24'h400000, 24'hC00000, 24'h200000};
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed points with hand-derived results.
    issue(24'h300000, 32'h3F400000, lat_sel(5));
    issue(24'h800000, 32'hC0000000, 3);
    issue(24'hD00000, 32'hBF400000, lat_sel(5));
    issue(24'h000000, 32'h00000000, 3);
    issue(24'h000001, 32'h34800000, lat_sel(26));

    // Enable held low mid-conversion and again across the done cycle.
    issue(24'h400000, 32'h3F800000, lat_sel(4));
    clk_en = 1'b0;
    repeat (4) @(negedge clk);
    clk_en = 1'b1;
    g = 0;
    while (!done && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", g);
    end
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    clk_en = 1'b1;

    // Start pulses with fresh data while busy must be ignored.
    issue(24'h000100, 32'h38800000, lat_sel(18));
    ign_start = 1'b1;
    issue(24'h300000, 32'h3F400000, lat_sel(5));
    ign_start = 1'b0;

    // Reset while in NORM, then a clean conversion.
    wait_idle();
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = 24'h000001;
    @(negedge clk);
    start  = 1'b0;
    reset  = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(24'hD00000, 32'hBF400000, lat_sel(5));

    // Random sweep with random enable gaps and ignored starts.
    rand_en   = 1'b1;
    ign_start = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       d = 24'($urandom);
        1:       d = 24'($urandom) >> $urandom_range(0, 23);
        2:       d = -(24'($urandom) >> $urandom_range(0, 23));
        default: d = corners[$urandom_range(0, 7)];
      endcase
      issue(d, ref_float(d), ref_lat(d));
    end

    rand_en   = 1'b0;
    ign_start = 1'b0;
    clk_en    = 1'b1;
    start     = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
